// File: rtl/sync_pulse_ctrl_if.sv
// MCU parallel write bus: active-low strobe plus address and data.
// The bus is fully asynchronous to the receiving clock; adr/data are held
// stable by the MCU for as long as wr_n is low.
//   wr_n : write strobe, active-low
//   adr  : register address
//   data : write data
interface sync_pulse_ctrl_if;
  logic        wr_n;
  logic [2:0]  adr;
  logic [15:0] data;

  modport master (output wr_n, adr, data);
  modport slave  (input  wr_n, adr, data);
endinterface

// File: rtl/sync_pulse_ctrl.sv
// Programmable delayed sync-pulse generator driven by MCU register writes.
// MCU writes are synchronised into the clk5mhz domain and stored in a small
// register file (CTRL/DELAY/WIDTH/PERIOD). A START write launches a one-shot
// or periodic pulse sequence timed in whole microseconds by the t1us tick.
//   clk5mhz  : 5 MHz system clock
//   rst_n    : asynchronous active-low reset
//   t1us     : one-cycle tick per microsecond
//   bus      : MCU write bus (wr_n, adr, data), asynchronous
//   sync_out : generated sync pulse (registered)
//   busy     : sequence in progress
//   done     : one-clock pulse at the end of a one-shot sequence
//   ctrl_rb  : {0, REPEAT, 0} debug readback
module sync_pulse_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk5mhz,
  input  logic                    rst_n,
  input  logic                    t1us,
  sync_pulse_ctrl_if.slave        bus,
  output logic                    sync_out,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              ctrl_rb
);

  typedef enum logic [1:0] {IDLE, DLY, PULSE, GAP} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // synchroniser chains
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic [2:0]             adr_sync_q  [SYNC_STAGES];
  logic [15:0]            data_sync_q [SYNC_STAGES];
  logic                   wr_prev_q;

  // register file
  logic                   repeat_q;
  logic [CNT_W-1:0]       delay_q, width_q, period_q;

  // sequencer
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       width_w_q, period_w_q;
  logic                   sync_q, done_q;

  logic                   wr_s, wr_ev, ctrl_wr, start_req, stop_req, last_tick;
  logic [2:0]             adr_s;
  logic [15:0]            data_s;
  logic [CNT_W-1:0]       start_width, run_width, gap_len;

  always_ff @(posedge clk5mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_q <= '0;
      wr_prev_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        adr_sync_q[i]  <= '0;
        data_sync_q[i] <= '0;
      end
    end else begin
      wr_sync_q      <= {wr_sync_q[SYNC_STAGES-2:0], bus.wr_n};
      wr_prev_q      <= wr_sync_q[SYNC_STAGES-1];
      adr_sync_q[0]  <= bus.adr;
      data_sync_q[0] <= bus.data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        adr_sync_q[i]  <= adr_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  always_comb begin
    wr_s   = wr_sync_q[SYNC_STAGES-1];
    adr_s  = adr_sync_q[SYNC_STAGES-1];
    data_s = data_sync_q[SYNC_STAGES-1];
    // falling edge of the synchronised strobe: one event per low period
    wr_ev     = !wr_s && wr_prev_q;
    ctrl_wr   = wr_ev && (adr_s == 3'd0);
    stop_req  = ctrl_wr && data_s[2];
    start_req = ctrl_wr && data_s[0] && !data_s[2];
    last_tick = t1us && (cnt_q == ONE);
    start_width = (width_q   == '0) ? ONE : width_q;
    run_width   = (width_w_q == '0) ? ONE : width_w_q;
    gap_len     = (period_w_q > width_w_q) ? (period_w_q - width_w_q) : ONE;
  end

  always_ff @(posedge clk5mhz or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
      delay_q  <= '0;
      width_q  <= '0;
      period_q <= '0;
    end else if (wr_ev) begin
      case (adr_s)
        3'd0:    repeat_q <= data_s[1];
        3'd1:    delay_q  <= CNT_W'(data_s);
        3'd2:    width_q  <= CNT_W'(data_s);
        3'd3:    period_q <= CNT_W'(data_s);
        default: ;
      endcase
    end
  end

  // The sequencer reads repeat_q and the working copies as they stand before
  // this edge, so a coincident bus write only affects later decisions.
  always_ff @(posedge clk5mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      width_w_q  <= '0;
      period_w_q <= '0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_req) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sync_q  <= 1'b0;
      end else begin
        if (state_q != IDLE && t1us && cnt_q > ONE)
          cnt_q <= cnt_q - ONE;
        case (state_q)
          IDLE: begin
            if (start_req) begin
              width_w_q  <= width_q;
              period_w_q <= period_q;
              if (delay_q == '0) begin
                state_q <= PULSE;
                cnt_q   <= start_width;
                sync_q  <= 1'b1;
              end else begin
                state_q <= DLY;
                cnt_q   <= delay_q;
              end
            end
          end
          DLY: begin
            if (last_tick) begin
              state_q <= PULSE;
              cnt_q   <= run_width;
              sync_q  <= 1'b1;
            end
          end
          PULSE: begin
            if (last_tick) begin
              sync_q <= 1'b0;
              if (repeat_q) begin
                state_q <= GAP;
                cnt_q   <= gap_len;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          GAP: begin
            if (last_tick) begin
              state_q <= PULSE;
              cnt_q   <= run_width;
              sync_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sync_out = sync_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign ctrl_rb  = {1'b0, repeat_q, 1'b0};

endmodule

// File: tb/tb_sync_pulse_ctrl.sv
// Self-checking bench for sync_pulse_ctrl: random t1us ticks, scripted and
// random MCU writes, every cycle compared against a tick-count model.
module tb_sync_pulse_ctrl;
  localparam int unsigned STG = 2;

  logic       clk5mhz, rst_n, t1us;
  logic       sync_out, busy, done;
  logic [2:0] ctrl_rb;

  sync_pulse_ctrl_if bus();

  sync_pulse_ctrl #(.CNT_W(16), .SYNC_STAGES(STG)) dut (
    .clk5mhz (clk5mhz),
    .rst_n   (rst_n),
    .t1us    (t1us),
    .bus     (bus),
    .sync_out(sync_out),
    .busy    (busy),
    .done    (done),
    .ctrl_rb (ctrl_rb)
  );

  initial clk5mhz = 1'b0;
  always #5 clk5mhz = ~clk5mhz;

  int unsigned vecs, miss;
  int unsigned cnt_hi, cnt_lo, cnt_done;

  // model: registers, pending bus event, and run described by tick count
  bit          m_rep;
  int          m_delay, m_width, m_period;
  int          pend_cnt;
  logic [2:0]  pend_a;
  logic [15:0] pend_d;
  bit          m_run, m_done;
  int          m_n, m_D, m_W, m_per;
  logic        e_sync, e_busy, e_done;
  logic [2:0]  e_rb;

  function automatic void model_outputs();
    e_busy = m_run;
    e_sync = m_run && (m_n >= m_D) && (((m_n - m_D) % m_per) < m_W);
    e_done = m_done;
    e_rb   = {1'b0, m_rep, 1'b0};
  endfunction

  function automatic void model_reset();
    m_rep = 0; m_delay = 0; m_width = 0; m_period = 0;
    pend_cnt = 0; pend_a = '0; pend_d = '0;
    m_run = 0; m_done = 0; m_n = 0; m_D = 0; m_W = 1; m_per = 1;
    model_outputs();
  endfunction

  function automatic void model_edge(input logic tk);
    bit ev, stp, sta;
    ev = 0;
    if (pend_cnt != 0) begin
      pend_cnt--;
      if (pend_cnt == 0) ev = 1;
    end
    stp = ev && (pend_a == 3'd0) && pend_d[2];
    sta = ev && (pend_a == 3'd0) && pend_d[0] && !pend_d[2];
    m_done = 0;
    if (stp) begin
      m_run = 0;
    end else if (m_run) begin
      if (tk) begin
        m_n++;
        if (m_n >= m_D && ((m_n - m_D) % m_per) == m_W && !m_rep) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (sta) begin
      m_run = 1;
      m_n   = 0;
      m_D   = m_delay;
      m_W   = (m_width == 0) ? 1 : m_width;
      m_per = m_W + ((m_period > m_width) ? (m_period - m_width) : 1);
    end
    if (ev) begin
      case (pend_a)
        3'd0: m_rep    = pend_d[1];
        3'd1: m_delay  = int'(pend_d);
        3'd2: m_width  = int'(pend_d);
        3'd3: m_period = int'(pend_d);
        default: ;
      endcase
    end
    model_outputs();
  endfunction

  // one clock: random isolated tick, model update, compare all outputs
  task automatic step();
    logic tk;
    tk = !t1us && ($urandom_range(0, 2) == 0);
    t1us = tk;
    if (tk && sync_out) cnt_hi++;
    if (tk && busy && !sync_out) cnt_lo++;
    @(posedge clk5mhz);
    model_edge(tk);
    #1;
    if (done) cnt_done++;
    vecs += 4;
    if (sync_out !== e_sync) begin miss++; $display("FAIL sync_out t=%0t: got %b want %b", $time, sync_out, e_sync); end
    if (busy !== e_busy)     begin miss++; $display("FAIL busy t=%0t: got %b want %b", $time, busy, e_busy); end
    if (done !== e_done)     begin miss++; $display("FAIL done t=%0t: got %b want %b", $time, done, e_done); end
    if (ctrl_rb !== e_rb)    begin miss++; $display("FAIL ctrl_rb t=%0t: got %b want %b", $time, ctrl_rb, e_rb); end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input int unsigned hold);
    bus.adr  = a;
    bus.data = d;
    step();
    bus.wr_n = 1'b0;
    pend_cnt = int'(STG) + 1;
    pend_a   = a;
    pend_d   = d;
    repeat (hold) step();
    bus.wr_n = 1'b1;
    bus.adr  = 3'($urandom);
    bus.data = 16'($urandom);
    repeat (STG + 1) step();
  endtask

  task automatic clr_counts();
    cnt_hi = 0; cnt_lo = 0; cnt_done = 0;
  endtask

  task automatic run_until_idle(input string tag);
    for (int i = 0; i < 3000 && m_run; i++) step();
    vecs++;
    if (m_run) begin miss++; $display("FAIL %s timeout: run still active, want idle", tag); end
  endtask

  task automatic run_ticks(input int n, input string tag);
    for (int i = 0; i < 3000 && m_n < n; i++) step();
    vecs++;
    if (m_n < n) begin miss++; $display("FAIL %s timeout: %0d ticks, want %0d", tag, m_n, n); end
  endtask

  task automatic check_cnt(input string tag, input int unsigned got, input int unsigned want);
    vecs++;
    if (got != want) begin miss++; $display("FAIL %s: got %0d want %0d", tag, got, want); end
  endtask

  task automatic test_reset();
    #12;
    vecs += 4;
    if (sync_out !== 1'b0) begin miss++; $display("FAIL por_sync: got %b want 0", sync_out); end
    if (busy !== 1'b0)     begin miss++; $display("FAIL por_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin miss++; $display("FAIL por_done: got %b want 0", done); end
    if (ctrl_rb !== 3'b0)  begin miss++; $display("FAIL por_rb: got %b want 000", ctrl_rb); end
    @(posedge clk5mhz); #1;
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_oneshot();
    bus_write(3'd1, 16'd3, 3);
    bus_write(3'd2, 16'd2, 3);
    clr_counts();
    bus_write(3'd0, 16'h0001, 3);
    run_until_idle("oneshot");
    check_cnt("oneshot_delay_ticks", cnt_lo, 3);
    check_cnt("oneshot_high_ticks", cnt_hi, 2);
    check_cnt("oneshot_done", cnt_done, 1);
  endtask

  task automatic test_periodic();
    bus_write(3'd1, 16'd0, 3);
    bus_write(3'd2, 16'd1, 3);
    bus_write(3'd3, 16'd5, 3);
    clr_counts();
    bus_write(3'd0, 16'h0003, 3);
    run_ticks(20, "periodic");
    check_cnt("periodic_high_ticks", cnt_hi, 4);
    check_cnt("periodic_no_done", cnt_done, 0);
    clr_counts();
    bus_write(3'd0, 16'h0004, 3);
    repeat (4) step();
    check_cnt("stop_no_done", cnt_done, 0);
    vecs++;
    if (busy !== 1'b0) begin miss++; $display("FAIL stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_edges();
    bus_write(3'd1, 16'd1, 3);
    bus_write(3'd2, 16'd0, 3);
    clr_counts();
    bus_write(3'd0, 16'h0001, 3);
    run_until_idle("width0");
    check_cnt("width0_high_ticks", cnt_hi, 1);
    check_cnt("width0_delay_ticks", cnt_lo, 1);
    bus_write(3'd1, 16'd0, 3);
    bus_write(3'd2, 16'd4, 3);
    bus_write(3'd3, 16'd2, 3);
    clr_counts();
    bus_write(3'd0, 16'h0003, 3);
    run_ticks(10, "short_period");
    check_cnt("short_period_high_ticks", cnt_hi, 8);
    check_cnt("short_period_gap_ticks", cnt_lo, 2);
    bus_write(3'd0, 16'h0004, 3);
    repeat (4) step();
    // unused addresses must not alias onto CTRL or DELAY
    bus_write(3'd4, 16'h0003, 3);
    bus_write(3'd5, 16'h0003, 3);
    vecs += 2;
    if (busy !== 1'b0)    begin miss++; $display("FAIL adr_unused_busy: got %b want 0", busy); end
    if (ctrl_rb !== 3'b0) begin miss++; $display("FAIL adr_unused_rb: got %b want 000", ctrl_rb); end
    clr_counts();
    bus_write(3'd0, 16'h0001, 3);
    run_until_idle("after_unused");
    check_cnt("after_unused_delay_ticks", cnt_lo, 0);
    check_cnt("after_unused_high_ticks", cnt_hi, 4);
  endtask

  task automatic test_bus_timing();
    bus_write(3'd1, 16'd2, 3);
    bus_write(3'd2, 16'd1, 3);
    clr_counts();
    bus_write(3'd0, 16'h0001, 50);
    run_until_idle("long_low");
    check_cnt("long_low_done", cnt_done, 1);
    check_cnt("long_low_delay_ticks", cnt_lo, 2);
    check_cnt("long_low_high_ticks", cnt_hi, 1);
    clr_counts();
    bus_write(3'd0, 16'h0005, 3);
    repeat (6) step();
    check_cnt("start_stop_done", cnt_done, 0);
    vecs++;
    if (busy !== 1'b0) begin miss++; $display("FAIL start_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    bus_write(3'd1, 16'd20, 3);
    bus_write(3'd2, 16'd2, 3);
    clr_counts();
    bus_write(3'd0, 16'h0001, 3);
    bus_write(3'd1, 16'd7, 3);
    bus_write(3'd0, 16'h0001, 3);
    run_until_idle("busy_start");
    check_cnt("busy_start_delay_ticks", cnt_lo, 20);
    check_cnt("busy_start_high_ticks", cnt_hi, 2);
    check_cnt("busy_start_done", cnt_done, 1);
    clr_counts();
    bus_write(3'd0, 16'h0001, 3);
    run_until_idle("new_delay");
    check_cnt("new_delay_ticks", cnt_lo, 7);
    check_cnt("new_delay_high_ticks", cnt_hi, 2);
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 3'($urandom_range(4, 7));
      else                           a = 3'($urandom_range(0, 3));
      case (a)
        3'd0:    d = 16'($urandom_range(0, 7));
        3'd1:    d = 16'($urandom_range(0, 5));
        3'd2:    d = 16'($urandom_range(0, 4));
        3'd3:    d = 16'($urandom_range(0, 8));
        default: d = 16'($urandom);
      endcase
      bus_write(a, d, $urandom_range(3, 6));
      repeat ($urandom_range(0, 15)) step();
    end
    bus_write(3'd0, 16'h0004, 3);
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    bus_write(3'd1, 16'd0, 3);
    bus_write(3'd2, 16'd10, 3);
    bus_write(3'd0, 16'h0003, 3);
    for (int i = 0; i < 200 && !e_sync; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    vecs += 4;
    if (sync_out !== 1'b0) begin miss++; $display("FAIL rst_mid_sync: got %b want 0", sync_out); end
    if (busy !== 1'b0)     begin miss++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin miss++; $display("FAIL rst_mid_done: got %b want 0", done); end
    if (ctrl_rb !== 3'b0)  begin miss++; $display("FAIL rst_mid_rb: got %b want 000", ctrl_rb); end
    model_reset();
    t1us = 1'b0;
    repeat (3) @(posedge clk5mhz);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    // registers cleared: START alone gives delay 0 and a 1-tick pulse
    clr_counts();
    bus_write(3'd0, 16'h0001, 3);
    run_until_idle("post_reset");
    check_cnt("post_reset_delay_ticks", cnt_lo, 0);
    check_cnt("post_reset_high_ticks", cnt_hi, 1);
    check_cnt("post_reset_done", cnt_done, 1);
  endtask

  initial begin
    vecs = 0; miss = 0;
    clr_counts();
    rst_n    = 1'b0;
    t1us     = 1'b0;
    bus.wr_n = 1'b1;
    bus.adr  = '0;
    bus.data = '0;
    model_reset();
    test_reset();
    test_oneshot();
    test_periodic();
    test_edges();
    test_bus_timing();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
